// File: rtl/fwd_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : fwd_hazard_unit
// Description : Operand-forwarding and load-use hazard unit for a 5-stage
//               pipeline. Tracks the EX/MEM/WB occupants, drives the EX
//               operand-select codes and the load-use stall, and keeps
//               saturating stall / forward performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
module fwd_hazard_unit #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              id_valid_i,
    input  logic [REG_AW-1:0] id_rs_i,
    input  logic [REG_AW-1:0] id_rt_i,
    input  logic              id_use_rt_i,
    input  logic [REG_AW-1:0] id_dst_i,
    input  logic              id_regwrite_i,
    input  logic              id_memread_i,
    input  logic              flush_i,
    output logic [1:0]        fwd_a_o,
    output logic [1:0]        fwd_b_o,
    output logic              stall_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  fwd_cnt_o
);

    localparam logic [1:0]        c_sel_rf  = 2'b00;
    localparam logic [1:0]        c_sel_mem = 2'b01;
    localparam logic [1:0]        c_sel_wb  = 2'b10;
    localparam logic [CNT_W-1:0]  c_cnt_one = CNT_W'(1);
    localparam logic [CNT_W-1:0]  c_cnt_max = '1;
    localparam logic [REG_AW-1:0] c_reg_zero = '0;

    // EX stage occupant
    logic              r_ex_valid;
    logic [REG_AW-1:0] r_ex_rs;
    logic [REG_AW-1:0] r_ex_rt;
    logic              r_ex_use_rt;
    logic [REG_AW-1:0] r_ex_dst;
    logic              r_ex_regwrite;
    logic              r_ex_memread;

    // MEM stage occupant
    logic              r_mem_valid;
    logic [REG_AW-1:0] r_mem_dst;
    logic              r_mem_regwrite;

    // WB stage occupant
    logic              r_wb_valid;
    logic [REG_AW-1:0] r_wb_dst;
    logic              r_wb_regwrite;

    logic [CNT_W-1:0]  r_stall_cnt;
    logic [CNT_W-1:0]  r_fwd_cnt;

    logic              w_stall;
    logic              w_bubble;
    logic              w_mem_src;
    logic              w_wb_src;
    logic [1:0]        w_fwd_a;
    logic [1:0]        w_fwd_b;
    logic              w_fwd_any;

    // Load-use hazard detection and forwarding-source qualification
    always_comb begin
        w_mem_src = r_mem_valid & r_mem_regwrite & (r_mem_dst != c_reg_zero);
        w_wb_src  = r_wb_valid  & r_wb_regwrite  & (r_wb_dst  != c_reg_zero);

        w_stall = r_ex_valid & r_ex_memread & r_ex_regwrite &
                  (r_ex_dst != c_reg_zero) & id_valid_i &
                  ((r_ex_dst == id_rs_i) |
                   (id_use_rt_i & (r_ex_dst == id_rt_i)));

        // A squashed or held-back instruction must not enter EX
        w_bubble = w_stall | flush_i;
    end

    // Operand-select codes; the younger (MEM) producer wins over WB
    always_comb begin
        w_fwd_a = c_sel_rf;
        w_fwd_b = c_sel_rf;

        if (w_mem_src && (r_mem_dst == r_ex_rs)) begin
            w_fwd_a = c_sel_mem;
        end else if (w_wb_src && (r_wb_dst == r_ex_rs)) begin
            w_fwd_a = c_sel_wb;
        end

        if (r_ex_use_rt) begin
            if (w_mem_src && (r_mem_dst == r_ex_rt)) begin
                w_fwd_b = c_sel_mem;
            end else if (w_wb_src && (r_wb_dst == r_ex_rt)) begin
                w_fwd_b = c_sel_wb;
            end
        end

        w_fwd_any = (w_fwd_a != c_sel_rf) | (w_fwd_b != c_sel_rf);
    end

    // EX stage load: ID instruction, or a bubble on stall / flush
    always_ff @(posedge clk_i) begin
        if (!rst_i || w_bubble) begin
            r_ex_valid    <= 1'b0;
            r_ex_rs       <= '0;
            r_ex_rt       <= '0;
            r_ex_use_rt   <= 1'b0;
            r_ex_dst      <= '0;
            r_ex_regwrite <= 1'b0;
            r_ex_memread  <= 1'b0;
        end else begin
            r_ex_valid    <= id_valid_i;
            r_ex_rs       <= id_rs_i;
            r_ex_rt       <= id_rt_i;
            r_ex_use_rt   <= id_use_rt_i;
            r_ex_dst      <= id_dst_i;
            r_ex_regwrite <= id_regwrite_i;
            r_ex_memread  <= id_memread_i;
        end
    end

    // MEM and WB stages shift unconditionally behind EX
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_mem_valid    <= 1'b0;
            r_mem_dst      <= '0;
            r_mem_regwrite <= 1'b0;
            r_wb_valid     <= 1'b0;
            r_wb_dst       <= '0;
            r_wb_regwrite  <= 1'b0;
        end else begin
            r_mem_valid    <= r_ex_valid;
            r_mem_dst      <= r_ex_dst;
            r_mem_regwrite <= r_ex_regwrite;
            r_wb_valid     <= r_mem_valid;
            r_wb_dst       <= r_mem_dst;
            r_wb_regwrite  <= r_mem_regwrite;
        end
    end

    // Saturating performance counters
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_stall_cnt <= '0;
            r_fwd_cnt   <= '0;
        end else begin
            if (w_stall && (r_stall_cnt != c_cnt_max)) begin
                r_stall_cnt <= r_stall_cnt + c_cnt_one;
            end
            if (w_fwd_any && (r_fwd_cnt != c_cnt_max)) begin
                r_fwd_cnt <= r_fwd_cnt + c_cnt_one;
            end
        end
    end

    assign fwd_a_o     = w_fwd_a;
    assign fwd_b_o     = w_fwd_b;
    assign stall_o     = w_stall;
    assign stall_cnt_o = r_stall_cnt;
    assign fwd_cnt_o   = r_fwd_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fwd_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fwd_hazard_unit
// Description : Directed self-checking bench for fwd_hazard_unit. Counters
//               are narrowed to 8 bits so saturation is reachable quickly.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fwd_hazard_unit;

    localparam int REG_AW = 5;
    localparam int CNT_W  = 8;

    logic              clk;
    logic              rst_i;
    logic              id_valid_i;
    logic [REG_AW-1:0] id_rs_i;
    logic [REG_AW-1:0] id_rt_i;
    logic              id_use_rt_i;
    logic [REG_AW-1:0] id_dst_i;
    logic              id_regwrite_i;
    logic              id_memread_i;
    logic              flush_i;
    logic [1:0]        fwd_a_o;
    logic [1:0]        fwd_b_o;
    logic              stall_o;
    logic [CNT_W-1:0]  stall_cnt_o;
    logic [CNT_W-1:0]  fwd_cnt_o;

    int total = 0;
    int bad   = 0;

    fwd_hazard_unit #(
        .REG_AW (REG_AW),
        .CNT_W  (CNT_W)
    ) u_dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .id_valid_i    (id_valid_i),
        .id_rs_i       (id_rs_i),
        .id_rt_i       (id_rt_i),
        .id_use_rt_i   (id_use_rt_i),
        .id_dst_i      (id_dst_i),
        .id_regwrite_i (id_regwrite_i),
        .id_memread_i  (id_memread_i),
        .flush_i       (flush_i),
        .fwd_a_o       (fwd_a_o),
        .fwd_b_o       (fwd_b_o),
        .stall_o       (stall_o),
        .stall_cnt_o   (stall_cnt_o),
        .fwd_cnt_o     (fwd_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock edge and settle away from it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present an ID-stage instruction: valid, rs, rt, use_rt, dst, regwrite, memread
    task automatic id(input logic v, input int rs, input int rt, input logic urt,
                      input int dst, input logic rw, input logic mr);
        id_valid_i    = v;
        id_rs_i       = REG_AW'(rs);
        id_rt_i       = REG_AW'(rt);
        id_use_rt_i   = urt;
        id_dst_i      = REG_AW'(dst);
        id_regwrite_i = rw;
        id_memread_i  = mr;
        #1;
    endtask

    task automatic nops(input int n);
        id(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        rst_i   = 1'b0;
        flush_i = 1'b0;
        id(0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        rst_i = 1'b1;
        #1;
        chk("rst_fwd_a", 32'(fwd_a_o), 0);
        chk("rst_fwd_b", 32'(fwd_b_o), 0);
        chk("rst_stall", 32'(stall_o), 0);
        chk("rst_stall_cnt", 32'(stall_cnt_o), 0);
        chk("rst_fwd_cnt", 32'(fwd_cnt_o), 0);

        // Back-to-back: add r3,r1,r2 ; sub r5,r3,r4
        id(1, 1, 2, 1, 3, 1, 0); tick();
        id(1, 3, 4, 1, 5, 1, 0); tick();
        chk("b2b_fwd_a", 32'(fwd_a_o), 1);
        chk("b2b_fwd_b", 32'(fwd_b_o), 0);
        chk("b2b_cnt_before", 32'(fwd_cnt_o), 0);
        nops(1);
        chk("b2b_cnt_after", 32'(fwd_cnt_o), 1);
        nops(3);

        // Distance 2: write r7 ; independent ; reader with rt=r7
        id(1, 1, 2, 1, 7, 1, 0);  tick();
        id(1, 1, 2, 1, 10, 1, 0); tick();
        id(1, 4, 7, 1, 11, 1, 0); tick();
        chk("d2_fwd_b", 32'(fwd_b_o), 2);
        chk("d2_fwd_a", 32'(fwd_a_o), 0);
        nops(3);

        // Double match: write r2 twice, then reader of r2 takes the younger
        id(1, 1, 1, 1, 2, 1, 0);  tick();
        id(1, 1, 1, 1, 2, 1, 0);  tick();
        id(1, 2, 0, 0, 12, 1, 0); tick();
        chk("dbl_fwd_a", 32'(fwd_a_o), 1);
        chk("dbl_fwd_b", 32'(fwd_b_o), 0);
        nops(3);

        // Load-use: lw r8 ; add r9,r8,r1
        id(1, 1, 0, 0, 8, 1, 1);
        chk("lu_no_stall_yet", 32'(stall_o), 0);
        tick();
        id(1, 8, 1, 1, 9, 1, 0);
        chk("lu_stall", 32'(stall_o), 1);
        chk("lu_cnt_before", 32'(stall_cnt_o), 0);
        tick();
        chk("lu_stall_once", 32'(stall_o), 0);
        chk("lu_stall_cnt", 32'(stall_cnt_o), 1);
        chk("lu_bubble_fwd_a", 32'(fwd_a_o), 0);
        tick();
        chk("lu_fwd_a", 32'(fwd_a_o), 2);
        chk("lu_fwd_b", 32'(fwd_b_o), 0);
        nops(1);
        chk("fwd_cnt_tally", 32'(fwd_cnt_o), 4);
        chk("stall_cnt_tally", 32'(stall_cnt_o), 1);
        nops(3);

        // r0 is never a hazard or a forwarding source
        id(1, 1, 2, 1, 0, 1, 0); tick();
        id(1, 1, 2, 0, 0, 1, 1); tick();
        id(1, 0, 0, 1, 13, 1, 0);
        chk("r0_no_stall", 32'(stall_o), 0);
        tick();
        chk("r0_fwd_a", 32'(fwd_a_o), 0);
        chk("r0_fwd_b", 32'(fwd_b_o), 0);
        nops(3);

        // rt matches a producer but is not used as an operand
        id(1, 1, 2, 1, 6, 1, 0);  tick();
        id(1, 1, 6, 0, 14, 1, 0); tick();
        chk("nort_fwd_b", 32'(fwd_b_o), 0);
        chk("nort_fwd_a", 32'(fwd_a_o), 0);
        nops(3);

        // Flushed producer of r4 must never be forwarded
        id(1, 1, 2, 1, 4, 1, 0);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        id(1, 4, 4, 1, 15, 1, 0); tick();
        chk("flush_fwd_a", 32'(fwd_a_o), 0);
        chk("flush_fwd_b", 32'(fwd_b_o), 0);
        nops(3);

        // Stall together with flush: stall still visible, EX still bubbled
        id(1, 1, 0, 0, 8, 1, 1); tick();
        id(1, 8, 8, 1, 9, 1, 0);
        flush_i = 1'b1;
        #1;
        chk("sf_stall", 32'(stall_o), 1);
        tick();
        flush_i = 1'b0;
        #1;
        chk("sf_bubble", 32'(stall_o), 0);
        nops(3);

        // Saturation: constant lw r8 <- r8 in ID stalls every other cycle
        rst_i = 1'b0;
        tick();
        rst_i = 1'b1;
        id(1, 8, 0, 0, 8, 1, 1);
        for (int i = 0; i < 508; i++) tick();
        chk("sat_stall_254", 32'(stall_cnt_o), 254);
        chk("sat_fwd_253", 32'(fwd_cnt_o), 253);
        tick(); tick();
        chk("sat_stall_max", 32'(stall_cnt_o), 255);
        chk("sat_fwd_254", 32'(fwd_cnt_o), 254);
        for (int i = 0; i < 12; i++) tick();
        chk("sat_stall_hold", 32'(stall_cnt_o), 255);
        chk("sat_fwd_hold", 32'(fwd_cnt_o), 255);

        // Reset mid-stall
        tick();
        chk("mid_stall_high", 32'(stall_o), 1);
        rst_i = 1'b0;
        tick();
        rst_i = 1'b1;
        #1;
        chk("mid_rst_stall", 32'(stall_o), 0);
        chk("mid_rst_stall_cnt", 32'(stall_cnt_o), 0);
        chk("mid_rst_fwd_cnt", 32'(fwd_cnt_o), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
